// File: rtl/memb_pkg.sv
// Shared types and defaults for the port-B memory arbiter.
package memb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 8;
   localparam int LAT_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } memb_state_e;

   // Memory latency is only meaningful in 1..4; clamp so a bad override cannot stall the FSM.
   function automatic logic [LAT_W-1:0] lat_load(input int lat);
      if (lat < 1)
         return LAT_W'(1);
      else if (lat > 4)
         return LAT_W'(4);
      else
         return LAT_W'(lat);
   endfunction

endpackage

// File: rtl/memb_arbiter_if.sv
// Requester handshakes plus memory port-B bus; slave = arbiter side, master = requesters/memory.
interface memb_arbiter_if #(
   parameter int ADDR_W = memb_pkg::ADDR_W_DEF,
   parameter int DATA_W = memb_pkg::DATA_W_DEF
);

   logic              req0, req1;
   logic              wr0, wr1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] address;
   logic              wren_b;
   logic [DATA_W-1:0] data_b;
   logic [DATA_W-1:0] q_b;

   modport slave (
      input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, q_b,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, address, wren_b, data_b
   );

   modport master (
      output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, q_b,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, address, wren_b, data_b
   );

endinterface

// File: rtl/memb_rr_pick.sv
// Two-way round-robin picker; the last-served pointer moves only when a grant is issued.
module memb_rr_pick (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   input  logic upd_id,
   output logic win_vld,
   output logic win_id
);

   logic last;

   // Reset to 1 so requester 0 wins the first contested pick.
   always_ff @(posedge clk) begin
      if (rst)
         last <= 1'b1;
      else if (upd)
         last <= upd_id;
   end

   always_comb begin
      win_vld = req0 | req1;
      win_id  = 1'b0;
      if (req0 && req1)
         win_id = ~last;
      else if (req1)
         win_id = 1'b1;
   end

endmodule

// File: rtl/memb_arbiter.sv
// Arbitrates two requesters onto a single memory port B: IDLE latches the winner,
// ISSUE drives the port for one cycle, WAIT counts out the read latency.
module memb_arbiter
   import memb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = 1
) (
   input logic          clk,
   input logic          rst,
   memb_arbiter_if.slave bus
);

   memb_state_e       state, state_nx;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              lat_wr, lat_id;
   logic [LAT_W-1:0]  cnt;
   logic              rvalid0_q, rvalid1_q;
   logic              win_vld, win_id;
   logic              take, issue, cap;

   memb_rr_pick u_pick (
      .clk     (clk),
      .rst     (rst),
      .req0    (bus.req0),
      .req1    (bus.req1),
      .upd     (issue),
      .upd_id  (lat_id),
      .win_vld (win_vld),
      .win_id  (win_id)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      take     = 1'b0;
      issue    = 1'b0;
      cap      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (win_vld) begin
               take     = 1'b1;
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue    = 1'b1;
            state_nx = lat_wr ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            // Last count is the cycle q_b is valid: capture it and free the port.
            if (cnt < LAT_W'(2)) begin
               cap      = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The latches double as the port-B address/data, so they hold outside ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wr    <= 1'b0;
         lat_id    <= 1'b0;
         cnt       <= '0;
         rdata_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= cap & ~lat_id;
         rvalid1_q <= cap & lat_id;
         if (take) begin
            lat_id    <= win_id;
            lat_wr    <= win_id ? bus.wr1    : bus.wr0;
            lat_addr  <= win_id ? bus.addr1  : bus.addr0;
            lat_wdata <= win_id ? bus.wdata1 : bus.wdata0;
         end
         if (issue && !lat_wr)
            cnt <= lat_load(MEM_LAT);
         else if (state == ST_WAIT && cnt != '0)
            cnt <= cnt - LAT_W'(1);
         if (cap)
            rdata_q <= bus.q_b;
      end
   end

   assign bus.gnt0    = issue & ~lat_id;
   assign bus.gnt1    = issue & lat_id;
   assign bus.wren_b  = issue & lat_wr;
   assign bus.address = lat_addr;
   assign bus.data_b  = lat_wdata;
   assign bus.rdata   = rdata_q;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;

   a_one_gnt: assert property (@(posedge clk) disable iff (rst) !(bus.gnt0 && bus.gnt1));
   a_one_rvalid: assert property (@(posedge clk) disable iff (rst) !(bus.rvalid0 && bus.rvalid1));
   a_wren_pulse: assert property (@(posedge clk) disable iff (rst) bus.wren_b |=> !bus.wren_b);

endmodule

// File: tb/tb_memb_arbiter.sv
// Directed bench: MEM_LAT=1 arbiter for function/fairness/reset, MEM_LAT=3 instance for latency.
module tb_memb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   wr_cnt_a = 0;

   memb_arbiter_if #(.ADDR_W(32), .DATA_W(8)) bus_a ();
   memb_arbiter_if #(.ADDR_W(32), .DATA_W(8)) bus_b ();

   memb_arbiter #(.ADDR_W(32), .DATA_W(8), .MEM_LAT(1)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   memb_arbiter #(.ADDR_W(32), .DATA_W(8), .MEM_LAT(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   // Memory A: 1-cycle synchronous read, writes counted.
   logic [7:0] mem_a [0:255];
   logic [7:0] pa0;
   always @(posedge clk) begin
      if (rst)
         mem_a[100] <= 8'd7;
      else if (bus_a.wren_b) begin
         mem_a[bus_a.address[7:0]] <= bus_a.data_b;
         wr_cnt_a <= wr_cnt_a + 1;
      end
      pa0 <= mem_a[bus_a.address[7:0]];
   end
   assign bus_a.q_b = pa0;

   // Memory B: read-only, 3-cycle pipeline, holds 7 at address 100.
   logic [7:0] pb0, pb1, pb2;
   always @(posedge clk) begin
      pb0 <= (bus_b.address == 32'd100) ? 8'd7 : 8'd0;
      pb1 <= pb0;
      pb2 <= pb1;
   end
   assign bus_b.q_b = pb2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      bus_a.req0 = 0; bus_a.req1 = 0; bus_a.wr0 = 0; bus_a.wr1 = 0;
      bus_a.addr0 = 0; bus_a.addr1 = 0; bus_a.wdata0 = 0; bus_a.wdata1 = 0;
      bus_b.req0 = 0; bus_b.req1 = 0; bus_b.wr0 = 0; bus_b.wr1 = 0;
      bus_b.addr0 = 0; bus_b.addr1 = 0; bus_b.wdata0 = 0; bus_b.wdata1 = 0;
      rst = 1'b1;
      repeat (2) step();

      // Reset values
      chk("rst_ctl", {bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1, bus_a.wren_b}, 0);
      chk("rst_addr", bus_a.address, 0);
      chk("rst_data_b", bus_a.data_b, 0);
      chk("rst_rdata", bus_a.rdata, 0);
      chk("rst_ctl_b", {bus_b.gnt0, bus_b.gnt1, bus_b.rvalid0, bus_b.rvalid1, bus_b.wren_b}, 0);
      rst = 1'b0;

      // Single read by requester 0
      bus_a.req0 = 1; bus_a.wr0 = 0; bus_a.addr0 = 100;
      step();
      chk("t1_gnt", {bus_a.gnt0, bus_a.gnt1, bus_a.wren_b}, 3'b100);
      chk("t1_addr", bus_a.address, 100);
      bus_a.req0 = 0;
      step();
      chk("t1_wait", {bus_a.gnt0, bus_a.rvalid0}, 0);
      step();
      chk("t1_rv", {bus_a.rvalid0, bus_a.rvalid1}, 2'b10);
      chk("t1_rdata", bus_a.rdata, 7);
      step();
      chk("t1_rv_end", bus_a.rvalid0, 0);

      // Single write by requester 1
      bus_a.req1 = 1; bus_a.wr1 = 1; bus_a.addr1 = 96; bus_a.wdata1 = 8'h2a;
      step();
      chk("t2_gnt", {bus_a.gnt0, bus_a.gnt1, bus_a.wren_b}, 3'b011);
      chk("t2_addr", bus_a.address, 96);
      chk("t2_data_b", bus_a.data_b, 8'h2a);
      bus_a.req1 = 0;
      step();
      chk("t2_done", {bus_a.gnt1, bus_a.wren_b}, 0);
      chk("t2_addr_hold", bus_a.address, 96);
      chk("t2_data_hold", bus_a.data_b, 8'h2a);
      chk("t2_wr_cnt", wr_cnt_a, 1);

      // Both reading continuously: 0,1,0,1 with rdata per requester
      bus_a.req0 = 1; bus_a.wr0 = 0; bus_a.addr0 = 100;
      bus_a.req1 = 1; bus_a.wr1 = 0; bus_a.addr1 = 96;
      for (int k = 1; k <= 12; k++) begin
         logic [3:0] e;
         step();
         e = {(k == 1 || k == 7), (k == 4 || k == 10), (k == 3 || k == 9), (k == 6 || k == 12)};
         chk("t3_seq", {bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1}, e);
         if (k == 3 || k == 9) chk("t3_rd0", bus_a.rdata, 7);
         if (k == 6 || k == 12) chk("t3_rd1", bus_a.rdata, 8'h2a);
         if (k == 11) begin
            bus_a.req0 = 0;
            bus_a.req1 = 0;
         end
      end

      // Requester 1 pulsed during WAIT must be dropped
      bus_a.req0 = 1; bus_a.wr0 = 0; bus_a.addr0 = 100;
      step();
      chk("t4_gnt", {bus_a.gnt0, bus_a.gnt1}, 2'b10);
      bus_a.req0 = 0;
      step();
      bus_a.req1 = 1; bus_a.wr1 = 1; bus_a.addr1 = 50; bus_a.wdata1 = 8'h55;
      step();
      chk("t4_rv", {bus_a.rvalid0, bus_a.gnt1}, 2'b10);
      chk("t4_rdata", bus_a.rdata, 7);
      bus_a.req1 = 0;
      step();
      chk("t4_no_gnt_a", {bus_a.gnt0, bus_a.gnt1, bus_a.wren_b}, 0);
      step();
      chk("t4_no_gnt_b", {bus_a.gnt0, bus_a.gnt1, bus_a.wren_b}, 0);
      chk("t4_wr_cnt", wr_cnt_a, 1);

      // Reset in WAIT aborts the read
      bus_a.req0 = 1; bus_a.wr0 = 0; bus_a.addr0 = 100;
      step();
      chk("t5_gnt", bus_a.gnt0, 1);
      bus_a.req0 = 0;
      step();
      rst = 1'b1;
      step();
      chk("t5_rst_ctl", {bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1, bus_a.wren_b}, 0);
      chk("t5_rst_addr", bus_a.address, 0);
      chk("t5_rst_rdata", bus_a.rdata, 0);
      rst = 1'b0;
      step();
      chk("t5_no_rv", bus_a.rvalid0, 0);
      // Pointer reset means requester 0 wins a contested pick
      bus_a.req0 = 1; bus_a.wr0 = 0; bus_a.addr0 = 100;
      bus_a.req1 = 1; bus_a.wr1 = 0; bus_a.addr1 = 96;
      step();
      chk("t5_first", {bus_a.gnt0, bus_a.gnt1}, 2'b10);
      bus_a.req0 = 0;
      step();
      step();
      chk("t5_rv0", bus_a.rvalid0, 1);
      chk("t5_rd0", bus_a.rdata, 7);
      step();
      chk("t5_second", {bus_a.gnt0, bus_a.gnt1}, 2'b01);
      bus_a.req1 = 0;
      step();
      step();
      chk("t5_rv1", bus_a.rvalid1, 1);
      chk("t5_rd1", bus_a.rdata, 8'h2a);

      // MEM_LAT=3: rvalid 5 cycles after the request is sampled
      bus_b.req0 = 1; bus_b.wr0 = 0; bus_b.addr0 = 100;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("tb_lat", {bus_b.gnt0, bus_b.rvalid0}, {(k == 1), (k == 5)});
         if (k == 1) bus_b.req0 = 0;
         if (k == 5) chk("tb_rdata", bus_b.rdata, 7);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/memb_arbiter.md
MEMB_ARBITER -- requirements
Module: memb_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, memory port-B address width.
REQ-002 Parameter DATA_W, 8, memory port-B data width.
REQ-003 Parameter MEM_LAT, 1, cycles from address issue to valid q_b (range 1-4).
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req0/req1  in  1  access request from requester 0 (debug host) / 1 (display fetch), held until granted.
REQ-007 wr0/wr1  in  1  1 = write, 0 = read; qualified by reqN.
REQ-008 addr0/addr1  in  ADDR_W  requested address.
REQ-009 wdata0/wdata1  in  DATA_W  write data.
REQ-010 gnt0/gnt1  out  1  one-cycle pulse: access issued to memory this cycle.
REQ-011 rvalid0/rvalid1  out  1  one-cycle pulse: rdata holds read result for that requester.
REQ-012 rdata  out  DATA_W  read data, shared by both requesters, qualified by rvalidN.
REQ-013 address  out  ADDR_W  memory port-B address.
REQ-014 wren_b  out  1  memory port-B write enable.
REQ-015 data_b  out  DATA_W  memory port-B write data.
REQ-016 q_b  in  DATA_W  memory port-B read data.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; encoding SHALL be a shared enum.
REQ-018 IDLE: no request -> stay IDLE; any reqN -> latch winner's addr/wr/wdata, go to ISSUE next cycle.
REQ-019 Arbitration round-robin: single request wins; both requesting -> requester not served last wins; after reset requester 0 has priority.
REQ-020 ISSUE: address/data_b driven from latched values, gntN high for exactly this cycle; wren_b = latched wr.
REQ-021 ISSUE write -> IDLE next cycle; ISSUE read -> WAIT, latency counter loaded with MEM_LAT.
REQ-022 WAIT: counter decrements each cycle; on the cycle q_b is valid (MEM_LAT cycles after ISSUE), rdata <= q_b and rvalidN pulses one cycle later; FSM returns to IDLE in that same cycle.
REQ-023 Latency: req sampled cycle N -> gnt in N+1 -> rvalid in N+2+MEM_LAT (read); write completes in N+1.
REQ-024 New requests SHALL NOT be sampled outside IDLE; a pending request stays pending and competes at next IDLE.
REQ-025 A request deasserted before its grant SHALL be dropped with no memory access.
REQ-026 wren_b SHALL be 0 in every state except ISSUE-with-write; never high for more than one cycle per grant.
REQ-027 address and data_b SHALL hold their last issued values outside ISSUE.
REQ-028 Fairness: while both request continuously, grants SHALL alternate 0,1,0,1.
REQ-029 At most one gnt and at most one rvalid high in any cycle.

Reset
REQ-030 rst high at a clock edge SHALL force IDLE, last-served pointer to 1 (so requester 0 wins first), counter 0.
REQ-031 Reset values: gnt0/1 0, rvalid0/1 0, wren_b 0, address 0, data_b 0, rdata 0.
REQ-032 Reset during ISSUE or WAIT SHALL abort the access; no rvalid SHALL follow for it.

Structure
REQ-033 Package memb_pkg SHALL hold the FSM state enum and default ADDR_W/DATA_W constants.
REQ-034 One sub-module memb_rr_pick SHALL hold the last-served flop and produce the winner from req0/req1; update on grant only.
REQ-035 FSM, latch registers and latency counter SHALL live in memb_arbiter.

Verification
REQ-036 After reset, req0=1 rd addr0=100, memory[100]=7 -> gnt0 one cycle later, address=100, rvalid0 at N+3 (MEM_LAT=1) with rdata=7.
REQ-037 req1=1 wr addr1=96 wdata1=8'h2A -> gnt1 and wren_b=1 for exactly one cycle with address=96, data_b=8'h2A; later read of 96 returns 8'h2A.
REQ-038 req0 and req1 both held reading 100 and 96 for 4 grants -> grant order 0,1,0,1; no cycle with two gnt.
REQ-039 rst asserted the cycle after gnt0 of a read -> no rvalid0, outputs at reset values next cycle, next req0 served normally.
REQ-040 req1 pulsed one cycle while FSM in WAIT -> no gnt1, no memory access for it.
REQ-041 MEM_LAT=3, req0 read 100 -> rvalid0 exactly 5 cycles after request sampled, rdata=7.
